// File: rtl/bank_isu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bank_isu_pkg
// Description : Shared sizes, types and helpers for the bank issue scheduler.
//               CHANNEL_NUM read channels plus one non-channel lane, an IQ of
//               DEPTH = 2**PTR_WIDTH entries, and the scheduler FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package bank_isu_pkg;

    localparam int CHANNEL_NUM = 3;
    localparam int PTR_WIDTH   = 6;
    localparam int DEPTH       = 1 << PTR_WIDTH;

    // Lanes: 0..CHANNEL_NUM-1 are read channels, LANE_NONCH is everything else.
    localparam int LANE_NUM    = CHANNEL_NUM + 1;
    localparam int LANE_NONCH  = 3;
    localparam int CH_ID_WIDTH = 2;

    typedef enum logic [1:0] {
        SCHED_RUN   = 2'd0,
        SCHED_DRAIN = 2'd1,
        SCHED_HALT  = 2'd2
    } sched_state_e;

    typedef logic [CH_ID_WIDTH-1:0] ch_id_t;
    typedef logic [PTR_WIDTH-1:0]   iq_ptr_t;
    typedef logic [DEPTH-1:0]       iq_vec_t;

    function automatic iq_vec_t ptr_onehot(input iq_ptr_t ptr);
        iq_vec_t v;
        v      = '0;
        v[ptr] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bank_isu_oldest_pick.sv
`default_nettype none
// ============================================================================
// Module      : bank_isu_oldest_pick
// Description : Combinational oldest-first picker. Returns the first set bit
//               of req_vec_i found scanning upward from bottom_ptr_i with
//               wrap from DEPTH-1 to 0.
// Ports       : req_vec_i    - candidate vector (one bit per IQ entry)
//               bottom_ptr_i - index of the oldest IQ entry
//               found_o      - at least one candidate present
//               ptr_o        - index of the oldest candidate (0 when none)
// Revision    : 1.0 - initial release
// ============================================================================
module bank_isu_oldest_pick
    import bank_isu_pkg::*;
#(
    parameter int PICK_PTR_WIDTH = PTR_WIDTH,
    parameter int PICK_DEPTH     = 1 << PICK_PTR_WIDTH
) (
    input  logic [PICK_DEPTH-1:0]     req_vec_i,
    input  logic [PICK_PTR_WIDTH-1:0] bottom_ptr_i,
    output logic                      found_o,
    output logic [PICK_PTR_WIDTH-1:0] ptr_o
);

    // Walk age offsets from youngest to oldest so the oldest hit overwrites
    // any younger one. DEPTH is a power of two, so the pointer add wraps
    // naturally and gives the modulo-DEPTH index directly.
    always_comb begin
        logic [PICK_PTR_WIDTH-1:0] idx;
        found_o = 1'b0;
        ptr_o   = '0;
        idx     = '0;
        for (int k = PICK_DEPTH - 1; k >= 0; k--) begin
            idx = bottom_ptr_i + PICK_PTR_WIDTH'(k);
            if (req_vec_i[idx]) begin
                found_o = 1'b1;
                ptr_o   = idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bank_isu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : bank_isu_issue_sched
// Description : Per-bank issue scheduler between the bank issue queue and the
//               bank pipeline. Picks one eligible IQ entry per cycle using
//               round-robin across lanes and oldest-first within a lane,
//               holds it in a registered valid/ready issue slot and pulses a
//               dequeue back to the IQ on handshake. A RUN/DRAIN/HALT FSM
//               lets bank control drain and halt issue.
// Ports       : clk, rst_n             - clock, async active-low reset
//               iq_valid_array         - IQ entry valid
//               credit_allow_array     - entry holds credit
//               iq_bottom_ptr          - oldest IQ entry
//               iq_entry_req_from_chN  - entry targets read channel N
//               iss_valid/ready/ptr/ch_id - issue slot handshake and payload
//               iq_deq_valid/ptr       - dequeue pulse to the IQ
//               flush_req, resume      - drain+halt request, leave halt
//               sched_halted           - scheduler is halted
// Revision    : 1.0 - initial release
// ============================================================================
module bank_isu_issue_sched
    import bank_isu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DEPTH-1:0]     iq_valid_array,
    input  logic [DEPTH-1:0]     credit_allow_array,
    input  logic [PTR_WIDTH-1:0] iq_bottom_ptr,
    input  logic [DEPTH-1:0]     iq_entry_req_from_ch0,
    input  logic [DEPTH-1:0]     iq_entry_req_from_ch1,
    input  logic [DEPTH-1:0]     iq_entry_req_from_ch2,
    output logic                 iss_valid,
    input  logic                 iss_ready,
    output logic [PTR_WIDTH-1:0] iss_ptr,
    output logic [1:0]           iss_ch_id,
    output logic                 iq_deq_valid,
    output logic [PTR_WIDTH-1:0] iq_deq_ptr,
    input  logic                 flush_req,
    input  logic                 resume,
    output logic                 sched_halted
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    sched_state_e state_q, state_d;
    logic         iss_valid_q, iss_valid_d;
    iq_ptr_t      iss_ptr_q, iss_ptr_d;
    ch_id_t       iss_ch_id_q, iss_ch_id_d;
    ch_id_t       rr_ptr_q, rr_ptr_d;
    iq_vec_t      issued_mask_q, issued_mask_d;
    logic         sched_halted_q;

    // ------------------------------------------------------------------
    // Eligibility and lane split
    // ------------------------------------------------------------------
    iq_vec_t eligible;
    iq_vec_t any_ch_req;
    iq_vec_t ch_req   [CHANNEL_NUM];
    iq_vec_t lane_vec [LANE_NUM];
    logic    [LANE_NUM-1:0] lane_found;
    iq_ptr_t lane_ptr [LANE_NUM];

    assign ch_req[0] = iq_entry_req_from_ch0;
    assign ch_req[1] = iq_entry_req_from_ch1;
    assign ch_req[2] = iq_entry_req_from_ch2;

    // Entries already sitting in (or having passed through) the slot stay
    // blocked until the IQ drops their valid bit.
    assign eligible   = iq_valid_array & credit_allow_array & ~issued_mask_q;
    assign any_ch_req = iq_entry_req_from_ch0 | iq_entry_req_from_ch1 |
                        iq_entry_req_from_ch2;

    generate
        for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch_lane
            assign lane_vec[g] = eligible & ch_req[g];
        end
    endgenerate

    assign lane_vec[LANE_NONCH] = eligible & ~any_ch_req;

    generate
        for (genvar g = 0; g < LANE_NUM; g++) begin : g_lane_pick
            bank_isu_oldest_pick #(
                .PICK_PTR_WIDTH (PTR_WIDTH),
                .PICK_DEPTH     (DEPTH)
            ) u_pick (
                .req_vec_i    (lane_vec[g]),
                .bottom_ptr_i (iq_bottom_ptr),
                .found_o      (lane_found[g]),
                .ptr_o        (lane_ptr[g])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin lane arbitration starting at rr_ptr_q
    // ------------------------------------------------------------------
    logic    win_found;
    ch_id_t  win_lane;
    iq_ptr_t win_ptr;

    // Offsets are walked from farthest to nearest so the lane closest to
    // rr_ptr_q (in circular order) is the one left standing.
    always_comb begin
        ch_id_t lane_idx;
        win_found = 1'b0;
        win_lane  = '0;
        win_ptr   = '0;
        lane_idx  = '0;
        for (int k = LANE_NUM - 1; k >= 0; k--) begin
            lane_idx = ch_id_t'((int'(rr_ptr_q) + k) % LANE_NUM);
            if (lane_found[lane_idx]) begin
                win_found = 1'b1;
                win_lane  = lane_idx;
                win_ptr   = lane_ptr[lane_idx];
            end
        end
    end

    // A flush request suppresses the load in the cycle it moves RUN -> DRAIN.
    logic load_en;
    logic handshake;

    assign handshake = iss_valid_q & iss_ready;
    assign load_en   = (state_q == SCHED_RUN) & ~flush_req & win_found &
                       (~iss_valid_q | iss_ready);

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCHED_RUN: begin
                if (flush_req) state_d = SCHED_DRAIN;
            end
            SCHED_DRAIN: begin
                // Slot empty, or its last occupant leaves this cycle.
                if (!iss_valid_q || iss_ready) state_d = SCHED_HALT;
            end
            SCHED_HALT: begin
                if (resume) state_d = SCHED_RUN;
            end
            default: state_d = SCHED_RUN;
        endcase
    end

    // ------------------------------------------------------------------
    // Issue slot, round-robin pointer and issued mask: next state
    // ------------------------------------------------------------------
    always_comb begin
        iss_valid_d   = iss_valid_q;
        iss_ptr_d     = iss_ptr_q;
        iss_ch_id_d   = iss_ch_id_q;
        rr_ptr_d      = rr_ptr_q;
        issued_mask_d = issued_mask_q & iq_valid_array;

        if (load_en) begin
            iss_valid_d   = 1'b1;
            iss_ptr_d     = win_ptr;
            iss_ch_id_d   = win_lane;
            rr_ptr_d      = (win_lane == ch_id_t'(LANE_NUM - 1)) ? '0
                                                                 : win_lane + 1'b1;
            // OR-ed in after the clear so a same-cycle set wins.
            issued_mask_d = issued_mask_d | ptr_onehot(win_ptr);
        end else if (handshake) begin
            iss_valid_d   = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= SCHED_RUN;
            iss_valid_q    <= 1'b0;
            iss_ptr_q      <= '0;
            iss_ch_id_q    <= '0;
            rr_ptr_q       <= '0;
            issued_mask_q  <= '0;
            sched_halted_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            iss_valid_q    <= iss_valid_d;
            iss_ptr_q      <= iss_ptr_d;
            iss_ch_id_q    <= iss_ch_id_d;
            rr_ptr_q       <= rr_ptr_d;
            issued_mask_q  <= issued_mask_d;
            sched_halted_q <= (state_d == SCHED_HALT);
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign iss_valid    = iss_valid_q;
    assign iss_ptr      = iss_ptr_q;
    assign iss_ch_id    = iss_ch_id_q;
    assign iq_deq_valid = handshake;
    assign iq_deq_ptr   = iss_ptr_q;
    assign sched_halted = sched_halted_q;

endmodule
`default_nettype wire

// File: tb/tb_bank_isu_issue_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_bank_isu_issue_sched
// Description : Self-checking bench for bank_isu_issue_sched. Directed steps
//               followed by a randomized phase, all compared against a
//               behavioural model that ranks eligible entries by age and
//               serves lanes round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_isu_issue_sched;
    import bank_isu_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [DEPTH-1:0]     iq_valid_array;
    logic [DEPTH-1:0]     credit_allow_array;
    logic [PTR_WIDTH-1:0] iq_bottom_ptr;
    logic [DEPTH-1:0]     iq_entry_req_from_ch0;
    logic [DEPTH-1:0]     iq_entry_req_from_ch1;
    logic [DEPTH-1:0]     iq_entry_req_from_ch2;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [PTR_WIDTH-1:0] iss_ptr;
    logic [1:0]           iss_ch_id;
    logic                 iq_deq_valid;
    logic [PTR_WIDTH-1:0] iq_deq_ptr;
    logic                 flush_req;
    logic                 resume;
    logic                 sched_halted;

    always #5 clk = ~clk;

    bank_isu_issue_sched dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .iq_valid_array        (iq_valid_array),
        .credit_allow_array    (credit_allow_array),
        .iq_bottom_ptr         (iq_bottom_ptr),
        .iq_entry_req_from_ch0 (iq_entry_req_from_ch0),
        .iq_entry_req_from_ch1 (iq_entry_req_from_ch1),
        .iq_entry_req_from_ch2 (iq_entry_req_from_ch2),
        .iss_valid             (iss_valid),
        .iss_ready             (iss_ready),
        .iss_ptr               (iss_ptr),
        .iss_ch_id             (iss_ch_id),
        .iq_deq_valid          (iq_deq_valid),
        .iq_deq_ptr            (iq_deq_ptr),
        .flush_req             (flush_req),
        .resume                (resume),
        .sched_halted          (sched_halted)
    );

    int checks = 0;
    int errors = 0;

    // Lane of each entry as the IQ sees it: 0..2 = channel, 3 = non-channel.
    int ent_lane [DEPTH];

    // Reference model state
    bit m_valid;
    int m_ptr;
    int m_ch;
    int m_rr;
    int m_state;            // 0 run, 1 drain, 2 halt
    bit m_mask [DEPTH];
    bit last_deq_v;
    int last_deq_p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic apply_lanes();
        for (int i = 0; i < DEPTH; i++) begin
            iq_entry_req_from_ch0[i] = (ent_lane[i] == 0);
            iq_entry_req_from_ch1[i] = (ent_lane[i] == 1);
            iq_entry_req_from_ch2[i] = (ent_lane[i] == 2);
        end
    endtask

    task automatic set_entry(input int idx, input bit v, input bit cr, input int lane);
        iq_valid_array[idx]     = v;
        credit_allow_array[idx] = cr;
        ent_lane[idx]           = lane;
        apply_lanes();
    endtask

    task automatic clear_iq();
        iq_valid_array     = '0;
        credit_allow_array = '0;
        for (int i = 0; i < DEPTH; i++) ent_lane[i] = 3;
        apply_lanes();
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_ptr      = 0;
        m_ch       = 0;
        m_rr       = 0;
        m_state    = 0;
        last_deq_v = 1'b0;
        last_deq_p = 0;
        for (int i = 0; i < DEPTH; i++) m_mask[i] = 1'b0;
    endtask

    function automatic int lane_of(input int i);
        if (iq_entry_req_from_ch0[i]) return 0;
        if (iq_entry_req_from_ch1[i]) return 1;
        if (iq_entry_req_from_ch2[i]) return 2;
        return 3;
    endfunction

    task automatic check_outputs();
        chk("iss_valid", {31'd0, iss_valid}, {31'd0, m_valid});
        if (m_valid) begin
            chk("iss_ptr", 32'(iss_ptr), 32'(m_ptr));
            chk("iss_ch_id", 32'(iss_ch_id), 32'(m_ch));
        end
        chk("deq_valid", {31'd0, iq_deq_valid}, {31'd0, (m_valid && iss_ready)});
        if (m_valid && iss_ready) chk("deq_ptr", 32'(iq_deq_ptr), 32'(m_ptr));
        chk("halted", {31'd0, sched_halted}, {31'd0, (m_state == 2)});
    endtask

    // One clock of the spec: list eligible entries oldest first, then give
    // the slot to the first lane (circularly from m_rr) that owns one.
    task automatic model_advance();
        int q[$];
        bit found;
        bit load;
        bit hs;
        int pick;
        int plane;
        int idx;
        int lane;
        for (int k = 0; k < DEPTH; k++) begin
            idx = (int'(iq_bottom_ptr) + k) % DEPTH;
            if (iq_valid_array[idx] && credit_allow_array[idx] && !m_mask[idx])
                q.push_back(idx);
        end
        found = 1'b0;
        pick  = 0;
        plane = 0;
        for (int j = 0; j < LANE_NUM; j++) begin
            lane = (m_rr + j) % LANE_NUM;
            foreach (q[n]) begin
                if (!found && lane_of(q[n]) == lane) begin
                    found = 1'b1;
                    pick  = q[n];
                    plane = lane;
                end
            end
        end
        load = (m_state == 0) && !flush_req && found && (!m_valid || iss_ready);
        hs   = m_valid && iss_ready;
        last_deq_v = hs;
        last_deq_p = m_ptr;

        case (m_state)
            0: if (flush_req) m_state = 1;
            1: if (!m_valid || iss_ready) m_state = 2;
            default: if (resume) m_state = 0;
        endcase

        for (int i = 0; i < DEPTH; i++) m_mask[i] = m_mask[i] && iq_valid_array[i];
        if (load) begin
            m_mask[pick] = 1'b1;
            m_valid      = 1'b1;
            m_ptr        = pick;
            m_ch         = plane;
            m_rr         = (plane + 1) % LANE_NUM;
        end else if (hs) begin
            m_valid = 1'b0;
        end
    endtask

    // Inputs change at posedge+1; outputs are checked at the negedge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("rst_iss_ptr", 32'(iss_ptr), 32'd0);
        chk("rst_iss_ch_id", 32'(iss_ch_id), 32'd0);
        chk("rst_deq_valid", {31'd0, iq_deq_valid}, 32'd0);
        chk("rst_halted", {31'd0, sched_halted}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int idx;
        rst_n         = 1'b0;
        iss_ready     = 1'b0;
        flush_req     = 1'b0;
        resume        = 1'b0;
        iq_bottom_ptr = '0;
        clear_iq();
        @(posedge clk);
        #1;
        do_reset();

        // Single read: entry 5 on ch1
        iss_ready = 1'b1;
        set_entry(5, 1'b1, 1'b1, 1);
        step();
        chk("single_ptr", 32'(iss_ptr), 32'd5);
        chk("single_ch", 32'(iss_ch_id), 32'd1);
        chk("single_deq", {31'd0, iq_deq_valid}, 32'd1);
        chk("single_deq_ptr", 32'(iq_deq_ptr), 32'd5);
        step();
        step();
        chk("no_reissue", {31'd0, iss_valid}, 32'd0);
        set_entry(5, 1'b0, 1'b0, 3);
        step();

        // Oldest-first with wrap
        iq_bottom_ptr = 6'd60;
        set_entry(2, 1'b1, 1'b1, 0);
        set_entry(62, 1'b1, 1'b1, 0);
        step();
        chk("wrap_first", 32'(iss_ptr), 32'd62);
        step();
        chk("wrap_second", 32'(iss_ptr), 32'd2);
        clear_iq();
        step();
        step();

        // Round robin from rr_ptr = 0
        do_reset();
        iq_bottom_ptr = '0;
        iss_ready     = 1'b1;
        set_entry(10, 1'b1, 1'b1, 0);
        set_entry(11, 1'b1, 1'b1, 1);
        set_entry(12, 1'b1, 1'b1, 2);
        set_entry(13, 1'b1, 1'b1, 3);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("rr_ch", 32'(iss_ch_id), 32'(n));
            chk("rr_ptr", 32'(iss_ptr), 32'(10 + n));
        end
        clear_iq();
        step();
        step();

        // Backpressure
        iss_ready = 1'b0;
        set_entry(7, 1'b1, 1'b1, 0);
        step();
        set_entry(8, 1'b1, 1'b1, 0);
        for (int n = 0; n < 4; n++) begin
            step();
            chk("bp_hold_ptr", 32'(iss_ptr), 32'd7);
            chk("bp_no_deq", {31'd0, iq_deq_valid}, 32'd0);
        end
        iss_ready = 1'b1;
        #1;
        chk("bp_deq", {31'd0, iq_deq_valid}, 32'd1);
        chk("bp_deq_ptr", 32'(iq_deq_ptr), 32'd7);
        step();
        chk("bp_next_ptr", 32'(iss_ptr), 32'd8);
        clear_iq();
        step();
        step();

        // Credit gating
        set_entry(3, 1'b1, 1'b0, 3);
        step();
        step();
        chk("credit_block", {31'd0, iss_valid}, 32'd0);
        set_entry(3, 1'b1, 1'b1, 3);
        step();
        chk("credit_issue", {31'd0, iss_valid}, 32'd1);
        chk("credit_ptr", 32'(iss_ptr), 32'd3);
        clear_iq();
        step();
        step();

        // Flush / drain / halt / resume
        iss_ready = 1'b0;
        set_entry(9, 1'b1, 1'b1, 2);
        step();
        chk("fl_slot", 32'(iss_ptr), 32'd9);
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        set_entry(20, 1'b1, 1'b1, 1);
        step();
        step();
        chk("fl_drain_hold", 32'(iss_ptr), 32'd9);
        iss_ready = 1'b1;
        #1;
        chk("fl_deq", {31'd0, iq_deq_valid}, 32'd1);
        chk("fl_deq_ptr", 32'(iq_deq_ptr), 32'd9);
        step();
        chk("fl_halted", {31'd0, sched_halted}, 32'd1);
        set_entry(9, 1'b0, 1'b0, 3);
        step();
        step();
        chk("fl_no_issue", {31'd0, iss_valid}, 32'd0);
        resume = 1'b1;
        step();
        resume = 1'b0;
        step();
        chk("fl_resume_ptr", 32'(iss_ptr), 32'd20);

        // Reset in the middle of a stall
        iss_ready = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, iss_valid}, 32'd0);
        chk("mid_rst_deq", {31'd0, iq_deq_valid}, 32'd0);
        model_reset();
        clear_iq();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Full IQ: every entry eligible, oldest is picked
        iss_ready     = 1'b1;
        iq_bottom_ptr = 6'd17;
        iq_valid_array     = '1;
        credit_allow_array = '1;
        step();
        chk("full_first", 32'(iss_ptr), 32'd17);
        step();
        chk("full_second", 32'(iss_ptr), 32'd18);
        clear_iq();
        step();
        step();

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            iss_ready = ($urandom_range(0, 3) != 0);
            flush_req = ($urandom_range(0, 59) == 0);
            resume    = ($urandom_range(0, 5) == 0);
            if (last_deq_v && $urandom_range(0, 3) != 0)
                iq_valid_array[last_deq_p] = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, DEPTH - 1);
                if (!iq_valid_array[idx]) begin
                    iq_valid_array[idx]     = 1'b1;
                    credit_allow_array[idx] = ($urandom_range(0, 3) != 0);
                    ent_lane[idx]           = $urandom_range(0, 3);
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, DEPTH - 1);
                credit_allow_array[idx] = ~credit_allow_array[idx];
            end
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, DEPTH - 1);
                iq_valid_array[idx] = 1'b0;
            end
            if ($urandom_range(0, 7) == 0)
                iq_bottom_ptr = PTR_WIDTH'($urandom_range(0, DEPTH - 1));
            apply_lanes();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
